tic_tac_toe_game: RTL and testbench
===================================

# tic_tac_toe_game

Sequential, parametrised N×N tic-tac-toe game controller; successor to the combinational 3×3 `ticTacToeWin` checker. It owns the board registers, accepts moves over a valid/ready handshake and alternates players, X first. It rejects illegal moves and scans the 2N+2 winning lines one per cycle to declare a win or a draw. It sits between the player-input front end and the display/score logic.

## Interface
- `N`, default 3: board side, legal range 3..8. The board has N*N cells and L = 2N+2 lines; a win requires a full row, column or diagonal.
- `PW`, default `$clog2(N*N)`: width of the move position field.

Ports:
- `clk` — in, 1 — single clock, rising edge.
- `rst_n` — in, 1 — reset, asynchronous and active-low.
- `new_game` — in, 1 — synchronous clear, usable in any state.
- `move_valid` — in, 1 — move request.
- `move_pos` — in, PW — cell bit index 0..N*N-1.
- `move_ready` — out, 1 — controller can accept a move.
- `grid_state_marked` — out, N*N — 1 = cell occupied.
- `grid_state_x` — out, N*N — 1 = cell held by X; only meaningful where marked.
- `turn_x` — out, 1 — 1 = X to move.
- `move_err` — out, 1 — one-cycle pulse: illegal move rejected.
- `someone_won` — out, 1 — game ended with a win.
- `player_x_won` — out, 1 — winner is X; valid while `someone_won` is high.
- `draw` — out, 1 — board full, no win.
- `game_over` — out, 1 — `someone_won | draw`.

## Operation
- Cell index i = r*N + c, with row 0 at the LSB. Row r uses bits r*N..r*N+N-1. Column c uses c, c+N, …. The main diagonal uses multiples of N+1. The anti-diagonal uses N-1, 2(N-1), …, N*(N-1).
- Line order for the scan: rows 0..N-1, columns 0..N-1, main diagonal, anti-diagonal.
- FSM states: PLAY, CHECK, DONE.
- PLAY: `move_ready`=1. A move is accepted on `move_valid & move_ready`.
  - If `move_pos` ≥ N*N or the cell is already marked: `move_err` pulses, nothing else changes, stay in PLAY.
  - Otherwise: set the marked bit, set the x bit = `turn_x`, latch mover = `turn_x`, clear the line counter, go to CHECK.
- CHECK: `move_ready`=0. Each cycle test line j for the mover: all cells marked and every x bit equal to the mover.
  - Hit: set `someone_won`=1 and `player_x_won`=mover, go to DONE.
  - Miss and j < L-1: increment j.
  - Miss and j = L-1: if the board is full, set `draw`=1 and go to DONE; otherwise toggle `turn_x` and go to PLAY.
  - Only the mover's lines are tested, because the opponent cannot have newly won.
- DONE: `move_ready`=0. Board and flags hold until `new_game`. `move_valid` is ignored with no `move_err`.
- Priority: `new_game` > undo (when configured) > move.
- `new_game` and reset produce the same values:
  - board all zeros;
  - `turn_x`=1;
  - `someone_won`, `player_x_won`, `draw`, `game_over`, `move_err` = 0;
  - `move_ready`=1;
  - state PLAY, line counter 0.
- `new_game` during CHECK abandons the scan.
- Async reset mid-scan returns immediately to the reset values.

## Timing
- Move accepted at edge E0: the board outputs show the new mark after E0. CHECK tests line j in the cycle following edge E0+j.
- A win on line j is flagged after edge E0+j+1.
- A non-winning move returns to PLAY, with `turn_x` toggled, after edge E0+L. `move_ready` reasserts in that cycle.
- `move_err` is high for exactly the one cycle after the rejecting edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `TTT_UNDO_EN` defined:
  - Adds input `undo` (1 bit) and a one-level last-move register plus a last-valid flag.
  - `undo` in PLAY with last-valid=1: clear that cell's marked and x bits, toggle `turn_x` back, clear last-valid. Takes one cycle.
  - `undo` in PLAY with last-valid=0: pulses `move_err`.
  - `undo` in CHECK or DONE: ignored.
  - `undo` and an accepted move in the same cycle: `undo` wins and the move is not consumed.
  - `new_game` clears last-valid.
- `TTT_UNDO_EN` undefined: no `undo` port and no last-move state.

## Structure
- Package `ttt_pkg`:
  - state enum `ttt_state_t` {PLAY, CHECK, DONE};
  - function `ttt_lines(N)` = 2N+2;
  - function `ttt_line_mask(N, j)` returning the N*N-bit cell mask of line j.
- Sub-module `ttt_line_check` (combinational): given the board, mask and mover, outputs `hit`. One instance, indexed by the line counter.

## Test plan
- **X wins top row (N=3):**
  - Stimulus: X at 6, O at 0, X at 7, O at 1, X at 8.
  - Required: `someone_won`=1 and `player_x_won`=1 after edge E0+3, where 6..8 is row 2, line j=2.
- **O wins the anti-diagonal:**
  - Stimulus: X at 0, O at 2, X at 1, O at 4, X at 5, O at 6.
  - Required: `someone_won`=1 and `player_x_won`=0, flagged at j=7.
- **Draw:**
  - Stimulus: moves 0,1,2,4,3,5,7,6,8 by alternating players.
  - Required: `draw`=1 and `game_over`=1 after the ninth move plus 8 cycles; `someone_won`=0.
- **Illegal moves:**
  - Stimulus: repeat cell 4; then `move_pos`=9 with N=3.
  - Required: each gives a single-cycle `move_err`; board and `turn_x` unchanged.
- **Mid-scan clear and async reset:**
  - Stimulus: `new_game` asserted during CHECK; separately, `rst_n` low mid-scan.
  - Required: board=0, `turn_x`=1, state PLAY next cycle; the async reset clears outputs without waiting for a clock edge.
- **`TTT_UNDO_EN` and N=4:**
  - Stimulus: X at 5, then `undo`.
  - Required: cell 5 cleared and `turn_x`=1; a second `undo` gives `move_err`.
  - Stimulus: N=4, X wins column 3 (cells 3,7,11,15).
  - Required: win flagged at j=7.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and line geometry for the N x N tic-tac-toe controller.
// Cell i = r*N + c; lines are rows, then columns, then main and anti-diagonal.
package ttt_pkg;

    typedef enum logic [1:0] {PLAY, CHECK, DONE} ttt_state_t;

    localparam int TTT_MAX_CELLS = 64;

    function automatic int ttt_lines(input int n);
        return 2 * n + 2;
    endfunction

    function automatic logic [TTT_MAX_CELLS-1:0] ttt_line_mask(input int n, input int j);
        logic [TTT_MAX_CELLS-1:0] m;
        int                       idx;
        m = '0;
        for (int k = 0; k < 8; k++) begin
            if (k < n) begin
                if (j < n)           idx = j * n + k;
                else if (j < 2 * n)  idx = (j - n) + k * n;
                else if (j == 2 * n) idx = k * (n + 1);
                else                 idx = (k + 1) * (n - 1);
                m[idx[5:0]] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/ttt_line_check.sv
// Combinational test of one winning line: every masked cell marked and owned by the mover.
module ttt_line_check #(
    parameter int N = 3
) (
    input  logic [N*N-1:0] i_marked,
    input  logic [N*N-1:0] i_x,
    input  logic [N*N-1:0] i_mask,
    input  logic           i_mover,
    output logic           o_hit
);

    logic w_all_marked;
    logic w_all_mover;

    assign w_all_marked = ((i_marked & i_mask) == i_mask);
    assign w_all_mover  = (((i_x ^ {(N*N){i_mover}}) & i_mask) == '0);
    assign o_hit        = w_all_marked & w_all_mover;

endmodule

// File: rtl/tic_tac_toe_game.sv
// N x N tic-tac-toe controller: owns the board, takes moves over valid/ready, scans one line per cycle.
// Optional single-level undo is compiled in when TTT_UNDO_EN is defined.
module tic_tac_toe_game
    import ttt_pkg::*;
#(
    parameter int N  = 3,
    parameter int PW = $clog2(N*N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          new_game,
    input  logic          move_valid,
    input  logic [PW-1:0] move_pos,
`ifdef TTT_UNDO_EN
    input  logic          undo,
`endif
    output logic          move_ready,
    output logic [N*N-1:0] grid_state_marked,
    output logic [N*N-1:0] grid_state_x,
    output logic          turn_x,
    output logic          move_err,
    output logic          someone_won,
    output logic          player_x_won,
    output logic          draw,
    output logic          game_over
);

    localparam int NN = N * N;
    localparam int L  = ttt_lines(N);
    localparam int LW = $clog2(L);
    localparam logic [PW:0]   NN_W   = NN[PW:0];
    localparam logic [LW-1:0] L_LAST = LW'(L - 1);

    ttt_state_t    r_state, w_state_nxt;
    logic [NN-1:0] r_marked, w_marked_nxt;
    logic [NN-1:0] r_x, w_x_nxt;
    logic          r_turn_x, w_turn_x_nxt;
    logic          r_mover, w_mover_nxt;
    logic [LW-1:0] r_line, w_line_nxt;
    logic          r_won, w_won_nxt;
    logic          r_pxwon, w_pxwon_nxt;
    logic          r_draw, w_draw_nxt;
    logic          r_err, w_err_nxt;
`ifdef TTT_UNDO_EN
    logic [PW-1:0] r_last_pos, w_last_pos_nxt;
    logic          r_last_valid, w_last_valid_nxt;
`endif

    logic [NN-1:0] w_masks [L];
    logic          w_hit;
    logic          w_legal;

    // Line masks are elaboration-time constants; the counter merely selects one.
    for (genvar g = 0; g < L; g++) begin : g_mask
        localparam logic [TTT_MAX_CELLS-1:0] M = ttt_line_mask(N, g);
        assign w_masks[g] = M[NN-1:0];
    end

    ttt_line_check #(.N(N)) u_line_check (
        .i_marked (r_marked),
        .i_x      (r_x),
        .i_mask   (w_masks[r_line]),
        .i_mover  (r_mover),
        .o_hit    (w_hit)
    );

    assign w_legal = ({1'b0, move_pos} < NN_W) && !r_marked[move_pos];

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_marked_nxt = r_marked;
        w_x_nxt      = r_x;
        w_turn_x_nxt = r_turn_x;
        w_mover_nxt  = r_mover;
        w_line_nxt   = r_line;
        w_won_nxt    = r_won;
        w_pxwon_nxt  = r_pxwon;
        w_draw_nxt   = r_draw;
        w_err_nxt    = 1'b0;
`ifdef TTT_UNDO_EN
        w_last_pos_nxt   = r_last_pos;
        w_last_valid_nxt = r_last_valid;
`endif
        if (new_game) begin
            w_state_nxt  = PLAY;
            w_marked_nxt = '0;
            w_x_nxt      = '0;
            w_turn_x_nxt = 1'b1;
            w_mover_nxt  = 1'b0;
            w_line_nxt   = '0;
            w_won_nxt    = 1'b0;
            w_pxwon_nxt  = 1'b0;
            w_draw_nxt   = 1'b0;
`ifdef TTT_UNDO_EN
            w_last_valid_nxt = 1'b0;
`endif
        end else begin
            case (r_state)
                PLAY: begin
`ifdef TTT_UNDO_EN
                    if (undo) begin
                        if (r_last_valid) begin
                            w_marked_nxt[r_last_pos] = 1'b0;
                            w_x_nxt[r_last_pos]      = 1'b0;
                            w_turn_x_nxt             = ~r_turn_x;
                            w_last_valid_nxt         = 1'b0;
                        end else begin
                            w_err_nxt = 1'b1;
                        end
                    end else
`endif
                    if (move_valid) begin
                        if (!w_legal) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_marked_nxt[move_pos] = 1'b1;
                            w_x_nxt[move_pos]      = r_turn_x;
                            w_mover_nxt            = r_turn_x;
                            w_line_nxt             = '0;
                            w_state_nxt            = CHECK;
`ifdef TTT_UNDO_EN
                            w_last_pos_nxt   = move_pos;
                            w_last_valid_nxt = 1'b1;
`endif
                        end
                    end
                end
                CHECK: begin
                    if (w_hit) begin
                        w_won_nxt   = 1'b1;
                        w_pxwon_nxt = r_mover;
                        w_state_nxt = DONE;
                    end else if (r_line == L_LAST) begin
                        if (&r_marked) begin
                            w_draw_nxt  = 1'b1;
                            w_state_nxt = DONE;
                        end else begin
                            w_turn_x_nxt = ~r_turn_x;
                            w_state_nxt  = PLAY;
                        end
                    end else begin
                        w_line_nxt = r_line + 1'b1;
                    end
                end
                DONE:    ;
                default: w_state_nxt = PLAY;
            endcase
        end
    end

    // NOTE: the board is a handful of flops, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= PLAY;
            r_marked <= '0;
            r_x      <= '0;
            r_turn_x <= 1'b1;
            r_mover  <= 1'b0;
            r_line   <= '0;
            r_won    <= 1'b0;
            r_pxwon  <= 1'b0;
            r_draw   <= 1'b0;
            r_err    <= 1'b0;
`ifdef TTT_UNDO_EN
            r_last_pos   <= '0;
            r_last_valid <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values of its peers.
            r_state  <= w_state_nxt;
            r_marked <= w_marked_nxt;
            r_x      <= w_x_nxt;
            r_turn_x <= w_turn_x_nxt;
            r_mover  <= w_mover_nxt;
            r_line   <= w_line_nxt;
            r_won    <= w_won_nxt;
            r_pxwon  <= w_pxwon_nxt;
            r_draw   <= w_draw_nxt;
            r_err    <= w_err_nxt;
`ifdef TTT_UNDO_EN
            r_last_pos   <= w_last_pos_nxt;
            r_last_valid <= w_last_valid_nxt;
`endif
        end
    end

    assign move_ready        = (r_state == PLAY);
    assign grid_state_marked = r_marked;
    assign grid_state_x      = r_x;
    assign turn_x            = r_turn_x;
    assign move_err          = r_err;
    assign someone_won       = r_won;
    assign player_x_won      = r_pxwon;
    assign draw              = r_draw;
    assign game_over         = r_won | r_draw;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Bench for tic_tac_toe_game: a 3x3 instance against a coordinate-based game model, plus a 4x4 column win.
// Undo scenarios are exercised when TTT_UNDO_EN is defined.
module tb_tic_tac_toe_game;

    localparam int N   = 3;
    localparam int NN  = 9;
    localparam int L   = 8;
    localparam int PW  = 4;
    localparam int L4  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          new_game = 1'b0;
    logic          move_valid = 1'b0;
    logic [PW-1:0] move_pos = '0;
    logic          undo = 1'b0;
    logic          move_ready, turn_x, move_err, someone_won, player_x_won, draw, game_over;
    logic [NN-1:0] marked, xbits;

    logic          new_game4 = 1'b0;
    logic          move_valid4 = 1'b0;
    logic [3:0]    move_pos4 = '0;
    logic          undo4 = 1'b0;
    logic          move_ready4, turn_x4, move_err4, someone_won4, player_x_won4, draw4, game_over4;
    logic [15:0]   marked4, xbits4;

    int checks = 0;
    int errors = 0;

    int cells [NN];   // 0 empty, 1 X, 2 O
    bit model_turn_x;
    bit model_over;
    int last_pos;
    bit last_valid;

    always #5 clk = ~clk;

    tic_tac_toe_game #(.N(N)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .new_game          (new_game),
        .move_valid        (move_valid),
        .move_pos          (move_pos),
`ifdef TTT_UNDO_EN
        .undo              (undo),
`endif
        .move_ready        (move_ready),
        .grid_state_marked (marked),
        .grid_state_x      (xbits),
        .turn_x            (turn_x),
        .move_err          (move_err),
        .someone_won       (someone_won),
        .player_x_won      (player_x_won),
        .draw              (draw),
        .game_over         (game_over)
    );

    tic_tac_toe_game #(.N(4)) dut4 (
        .clk               (clk),
        .rst_n             (rst_n),
        .new_game          (new_game4),
        .move_valid        (move_valid4),
        .move_pos          (move_pos4),
`ifdef TTT_UNDO_EN
        .undo              (undo4),
`endif
        .move_ready        (move_ready4),
        .grid_state_marked (marked4),
        .grid_state_x      (xbits4),
        .turn_x            (turn_x4),
        .move_err          (move_err4),
        .someone_won       (someone_won4),
        .player_x_won      (player_x_won4),
        .draw              (draw4),
        .game_over         (game_over4)
    );

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Membership from (row, column) coordinates.
    function automatic bit in_line(input int j, input int i);
        int r, c;
        r = i / N;
        c = i % N;
        if (j < N)       return r == j;
        if (j < 2 * N)   return c == j - N;
        if (j == 2 * N)  return r == c;
        return (r + c) == N - 1;
    endfunction

    function automatic int first_win(input int p);
        bit all_p;
        for (int j = 0; j < L; j++) begin
            all_p = 1'b1;
            for (int i = 0; i < NN; i++)
                if (in_line(j, i) && cells[i] != p) all_p = 1'b0;
            if (all_p) return j;
        end
        return -1;
    endfunction

    function automatic bit board_full();
        for (int i = 0; i < NN; i++) if (cells[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [NN-1:0] exp_marked();
        logic [NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i] = (cells[i] != 0);
        return v;
    endfunction

    function automatic logic [NN-1:0] exp_x();
        logic [NN-1:0] v;
        for (int i = 0; i < NN; i++) v[i] = (cells[i] == 1);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < NN; i++) cells[i] = 0;
        model_turn_x = 1'b1;
        model_over   = 1'b0;
        last_valid   = 1'b0;
    endtask

    task automatic start_game();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
    endtask

    // Drive one move and follow it through the whole scan, checking the model's timing.
    task automatic play_move(input int pos);
        int  mover;
        int  j;
        move_valid = 1'b1;
        move_pos   = pos[PW-1:0];
        step();
        move_valid = 1'b0;
        if (model_over) begin
            checks++;
            if (move_err !== 1'b0 || marked !== exp_marked() || game_over !== 1'b1) begin
                errors++;
                $display("FAIL done_ignore pos=%0d: err=%b marked=%h over=%b, want err=0 marked=%h over=1",
                         pos, move_err, marked, game_over, exp_marked());
            end
            return;
        end
        if (pos >= NN || cells[pos] != 0) begin
            checks++;
            if (move_err !== 1'b1 || marked !== exp_marked() || xbits !== exp_x() ||
                turn_x !== model_turn_x || move_ready !== 1'b1) begin
                errors++;
                $display("FAIL illegal pos=%0d: err=%b marked=%h x=%h turn=%b ready=%b, want err=1 marked=%h x=%h turn=%b ready=1",
                         pos, move_err, marked, xbits, turn_x, move_ready, exp_marked(), exp_x(), model_turn_x);
            end
            step();
            checks++;
            if (move_err !== 1'b0) begin
                errors++;
                $display("FAIL err_pulse_width pos=%0d: err=%b want 0", pos, move_err);
            end
            return;
        end
        mover      = model_turn_x ? 1 : 2;
        cells[pos] = mover;
        last_pos   = pos;
        last_valid = 1'b1;
        checks++;
        if (marked !== exp_marked() || xbits !== exp_x() || move_ready !== 1'b0 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL board_update pos=%0d: marked=%h x=%h ready=%b err=%b, want marked=%h x=%h ready=0 err=0",
                     pos, marked, xbits, move_ready, move_err, exp_marked(), exp_x());
        end
        j = first_win(mover);
        if (j >= 0) begin
            repeat (j) step();
            checks++;
            if (someone_won !== 1'b0) begin
                errors++;
                $display("FAIL win_early line=%0d: won=%b want 0", j, someone_won);
            end
            step();
            checks++;
            if (someone_won !== 1'b1 || player_x_won !== model_turn_x || game_over !== 1'b1 || move_ready !== 1'b0) begin
                errors++;
                $display("FAIL win line=%0d: won=%b px=%b over=%b ready=%b, want won=1 px=%b over=1 ready=0",
                         j, someone_won, player_x_won, game_over, move_ready, model_turn_x);
            end
            model_over = 1'b1;
        end else begin
            repeat (L - 1) step();
            checks++;
            if (move_ready !== 1'b0 || game_over !== 1'b0) begin
                errors++;
                $display("FAIL scan_length pos=%0d: ready=%b over=%b want ready=0 over=0", pos, move_ready, game_over);
            end
            step();
            if (board_full()) begin
                checks++;
                if (draw !== 1'b1 || game_over !== 1'b1 || someone_won !== 1'b0 || move_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL draw: draw=%b over=%b won=%b ready=%b, want 1 1 0 0", draw, game_over, someone_won, move_ready);
                end
                model_over = 1'b1;
            end else begin
                model_turn_x = !model_turn_x;
                checks++;
                if (move_ready !== 1'b1 || turn_x !== model_turn_x || draw !== 1'b0 || someone_won !== 1'b0) begin
                    errors++;
                    $display("FAIL return_play pos=%0d: ready=%b turn=%b draw=%b won=%b, want ready=1 turn=%b draw=0 won=0",
                             pos, move_ready, turn_x, draw, someone_won, model_turn_x);
                end
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (marked !== '0 || xbits !== '0 || turn_x !== 1'b1 || move_ready !== 1'b1 || move_err !== 1'b0 ||
            someone_won !== 1'b0 || player_x_won !== 1'b0 || draw !== 1'b0 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL reset: marked=%h x=%h turn=%b ready=%b err=%b won=%b px=%b draw=%b over=%b",
                     marked, xbits, turn_x, move_ready, move_err, someone_won, player_x_won, draw, game_over);
        end
    endtask

    task automatic test_x_row();
        int seq [5] = '{6, 0, 7, 1, 8};
        start_game();
        foreach (seq[i]) play_move(seq[i]);
        play_move(3);
    endtask

    task automatic test_o_antidiag();
        int seq [6] = '{0, 2, 1, 4, 5, 6};
        start_game();
        foreach (seq[i]) play_move(seq[i]);
    endtask

    task automatic test_draw();
        int seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
        start_game();
        foreach (seq[i]) play_move(seq[i]);
    endtask

    task automatic test_illegal();
        start_game();
        play_move(4);
        play_move(4);
        play_move(9);
        play_move(15);
    endtask

    task automatic test_midscan_clear();
        start_game();
        move_valid = 1'b1;
        move_pos   = 4'd4;
        step();
        move_valid = 1'b0;
        step();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        checks++;
        if (marked !== '0 || xbits !== '0 || turn_x !== 1'b1 || move_ready !== 1'b1 || game_over !== 1'b0) begin
            errors++;
            $display("FAIL midscan_clear: marked=%h x=%h turn=%b ready=%b over=%b", marked, xbits, turn_x, move_ready, game_over);
        end
        move_valid = 1'b1;
        move_pos   = 4'd0;
        step();
        move_valid = 1'b0;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (marked !== '0 || turn_x !== 1'b1 || move_ready !== 1'b1 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: marked=%h turn=%b ready=%b err=%b", marked, turn_x, move_ready, move_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        play_move(2);
    endtask

`ifdef TTT_UNDO_EN
    task automatic test_undo();
        start_game();
        play_move(5);
        undo = 1'b1;
        step();
        undo = 1'b0;
        cells[5]     = 0;
        model_turn_x = 1'b1;
        last_valid   = 1'b0;
        checks++;
        if (marked !== exp_marked() || xbits !== exp_x() || turn_x !== 1'b1 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL undo: marked=%h x=%h turn=%b err=%b, want marked=%h turn=1 err=0", marked, xbits, turn_x, move_err, exp_marked());
        end
        undo = 1'b1;
        step();
        undo = 1'b0;
        checks++;
        if (move_err !== 1'b1 || turn_x !== 1'b1) begin
            errors++;
            $display("FAIL undo_twice: err=%b turn=%b, want err=1 turn=1", move_err, turn_x);
        end
        play_move(5);
    endtask
`endif

    task automatic test_n4_column();
        int seq [7] = '{3, 0, 7, 1, 11, 2, 15};
        int k;
        new_game4 = 1'b1;
        step();
        new_game4 = 1'b0;
        foreach (seq[i]) begin
            move_valid4 = 1'b1;
            move_pos4   = seq[i][3:0];
            step();
            move_valid4 = 1'b0;
            if (i < 6) begin
                repeat (L4) step();
                checks++;
                if (move_ready4 !== 1'b1 || turn_x4 !== (i % 2 == 1)) begin
                    errors++;
                    $display("FAIL n4_turn move=%0d: ready=%b turn=%b want ready=1 turn=%b", i, move_ready4, turn_x4, (i % 2 == 1));
                end
            end else begin
                k = 0;
                while (someone_won4 !== 1'b1 && k < 20) begin
                    step();
                    k++;
                end
                checks++;
                if (k != 8 || player_x_won4 !== 1'b1 || marked4 !== 16'h888F) begin
                    errors++;
                    $display("FAIL n4_column_win: edges=%0d px=%b marked=%h, want edges=8 px=1 marked=888f", k, player_x_won4, marked4);
                end
            end
        end
    endtask

    task automatic test_random();
        int pos;
        for (int g = 0; g < 8; g++) begin
            start_game();
            for (int m = 0; m < 30 && !model_over; m++) begin
                if ($urandom_range(0, 3) == 0) pos = $urandom_range(0, 15);
                else begin
                    pos = $urandom_range(0, NN - 1);
                    for (int t = 0; t < NN && cells[pos] != 0; t++) pos = (pos + 1) % NN;
                end
                play_move(pos);
            end
        end
    endtask

    initial begin
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_x_row();
        test_o_antidiag();
        test_draw();
        test_illegal();
        test_midscan_clear();
`ifdef TTT_UNDO_EN
        test_undo();
`endif
        test_n4_column();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
